segmentos_mux_n: RTL

Parametrised N-digit multiplexed 7-segment driver. It is the successor of the fixed 4-digit hours/minutes driver. It takes one W-bit binary value and converts it to BCD with a sequential double-dabble FSM, or passes it through as hex nibbles. The converted digits are committed atomically to a shadow register and scanned onto common-anode displays using a clock-enable tick, with no derived clock. It adds leading-zero blanking, per-digit blink and an overflow indication. It sits between the wishbone control registers and the board display pins.

---
 rtl/segmentos_mux_n.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/segmentos_mux_n.sv
// N-digit multiplexed common-anode 7-segment driver with a sequential double-dabble
// converter, atomic shadow commit, leading-zero blanking, per-digit blink and overflow dashes.
module segmentos_mux_n #(
    parameter int N_DIGITS     = 4,
    parameter int W            = 16,
    parameter int DIV          = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                load,
    input  logic [W-1:0]        value,
    input  logic                hex_mode,
    input  logic                blank_lz,
    input  logic [N_DIGITS-1:0] dp,
    input  logic [N_DIGITS-1:0] blink_mask,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [7:0]          bcd,
    output logic [N_DIGITS-1:0] anodos
);

    localparam int AW = 4 * N_DIGITS;
    localparam int DW = $clog2(DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam int CW = $clog2(W + 1);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        sh_q, sh_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic [CW-1:0]       bit_q, bit_d;
    logic [AW-1:0]       shadow_q, shadow_d;
    logic                ovr_q, ovr_d;
    logic [DW-1:0]       div_q, div_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic                phase_q, phase_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [7:0]          seg_q, seg_d;

    logic [W+AW-1:0]     ext;
    logic [AW-1:0]       adj;
    logic                tick, wrap;
    logic [N_DIGITS-1:0] lz;
    logic                seen;
    logic [3:0]          digit;
    logic [7:0]          seg_sel;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    assign ext = {{AW{1'b0}}, value};

    // Conversion FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Conversion FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = hex_mode ? COMMIT : SHIFT;
            SHIFT:   if (bit_q == CW'(W - 1)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Conversion FSM: outputs
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == COMMIT);
    end

    // Double-dabble datapath; hex loads fill the accumulator directly
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < N_DIGITS; i++)
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        sh_d     = sh_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        bit_d    = bit_q;
        shadow_d = shadow_q;
        ovr_d    = ovr_q;
        case (state_q)
            IDLE: if (load) begin
                sh_d  = value;
                bit_d = '0;
                if (hex_mode) begin
                    acc_d = ext[AW-1:0];
                    ovf_d = |ext[W+AW-1:AW];
                end else begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end
            end
            SHIFT: begin
                acc_d = {adj[AW-2:0], sh_q[W-1]};
                ovf_d = ovf_q | adj[AW-1];
                sh_d  = sh_q << 1;
                bit_d = bit_q + CW'(1);
            end
            COMMIT: begin
                shadow_d = acc_q;
                ovr_d    = ovf_q;
            end
            default: ;
        endcase
    end

    // Scan timing: divider, index, frame counter and blink phase
    always_comb begin
        tick    = enable && (div_q == DW'(DIV - 1));
        wrap    = tick && (idx_q == IW'(N_DIGITS - 1));
        div_d   = div_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        phase_d = phase_q;
        if (enable) div_d = tick ? '0 : div_q + DW'(1);
        if (tick)   idx_d = wrap ? '0 : idx_q + IW'(1);
        if (wrap) begin
            if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end
    end

    // Segment selection uses next-state digits so a tick coinciding with commit shows new data
    always_comb begin
        seen = 1'b0;
        lz   = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            seen  = seen | (shadow_d[4*i +: 4] != 4'h0);
            lz[i] = !seen && (i != 0);
        end
        digit = shadow_d[{idx_d, 2'b00} +: 4];
        if (phase_d && blink_mask[idx_d])  seg_sel = 8'hFF;
        else if (ovr_d)                    seg_sel = {SEG_DASH, ~dp[idx_d]};
        else if (blank_lz && lz[idx_d])    seg_sel = {SEG_BLANK, ~dp[idx_d]};
        else                               seg_sel = {hex7(digit), ~dp[idx_d]};
    end

    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        if (!enable) begin
            an_d  = '1;
            seg_d = 8'hFF;
        end else if (tick) begin
            an_d  = ~(N_DIGITS'(1) << idx_d);
            seg_d = seg_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q     <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            bit_q    <= '0;
            shadow_q <= '0;
            ovr_q    <= 1'b0;
            div_q    <= '0;
            idx_q    <= '0;
            frame_q  <= '0;
            phase_q  <= 1'b0;
            an_q     <= '1;
            seg_q    <= 8'hFF;
        end else begin
            sh_q     <= sh_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            bit_q    <= bit_d;
            shadow_q <= shadow_d;
            ovr_q    <= ovr_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            phase_q  <= phase_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign overflow = ovr_q;
    assign bcd      = seg_q;
    assign anodos   = an_q;

endmodule
